uart_ctrl_regs: RTL and testbench
=================================

UART_CTRL_REGS -- requirements
Module: uart_ctrl_regs

Interface
REQ-001 Parameter DATA_W, default 32, bus data width (>=16).
REQ-002 Parameter CHAR_W, default 8, UART character width (<=DATA_W).
REQ-003 Parameter DIV_W, default 16, baud divisor width (<=DATA_W).
REQ-004 clk_i  in  1  single clock; all state sampled on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 addr_i  in  2  word select: 0 CTRL, 1 TXDATA, 2 RXDATA (read-only), 3 DIV.
REQ-007 wr_i  in  1  CPU write strobe, one cycle per write.
REQ-008 wdata_i  in  DATA_W  CPU write data.
REQ-009 rdata_o  out  DATA_W  combinational read of register at addr_i.
REQ-010 tx_start_o  out  1  start request to transmitter.
REQ-011 tx_data_o  out  CHAR_W  TXDATA[CHAR_W-1:0], held stable while SEND=1.
REQ-012 tx_busy_i  in  1  transmitter busy.
REQ-013 rx_valid_i  in  1  one-cycle pulse, new character on rx_data_i.
REQ-014 rx_data_i  in  CHAR_W  received character.
REQ-015 div_o  out  DIV_W  baud divisor (DIV register).
REQ-016 irq_o  out  1  interrupt request (see Configuration).

Function
REQ-017 CTRL bits: 0 SEND, 1 NEW, 2 OVR, 3 TXDONE, 4 IE_RX, 5 IE_TXDONE, 6 IE_OVR; other bits read 0.
REQ-018 CPU write of CTRL with bit0=1 while FSM is IDLE sets SEND; bit0 write is ignored otherwise.
REQ-019 Bits 1-3 are write-1-to-clear; bits 4-6 are plain read/write.
REQ-020 rx_valid_i captures rx_data_i into RXDATA and sets NEW in the same edge.
REQ-021 rx_valid_i while NEW=1 also sets OVR; RXDATA is overwritten with the new character.
REQ-022 Same-cycle hardware set and CPU write-1-to-clear of NEW/OVR/TXDONE: the set wins.
REQ-023 TX FSM states IDLE, START, WAIT; IDLE->START when SEND becomes 1.
REQ-024 START: tx_start_o=1; START->WAIT on the first cycle tx_busy_i=1.
REQ-025 WAIT: tx_start_o=0; WAIT->IDLE on tx_busy_i=0, with SEND cleared and TXDONE set on that edge.
REQ-026 CPU writes to TXDATA while SEND=1 are ignored.
REQ-027 Latency: write setting SEND -> tx_start_o high on the next cycle.
REQ-028 DIV is plain read/write of its low DIV_W bits; reads zero-extend to DATA_W.
REQ-029 RXDATA reads zero-extend to DATA_W; CPU writes to RXDATA have no effect.

Reset
REQ-030 rst_i=0 immediately clears all registers, sets FSM to IDLE, and drives tx_start_o=0 and irq_o=0, independent of clk_i.
REQ-031 Reset mid-transmission abandons the transfer; no TXDONE is produced after release.
REQ-032 DIV resets to 0; the first cycle after release behaves as idle.

Configuration
REQ-033 With macro UART_CTRL_IRQ_EN defined: irq_o is registered and equals (NEW&IE_RX)|(TXDONE&IE_TXDONE)|(OVR&IE_OVR), delayed one cycle.
REQ-034 Without UART_CTRL_IRQ_EN: irq_o is tied to 0, bits 4-6 read 0, and writes to them are ignored.

Verification
REQ-035 Write CTRL=0x1 with TXDATA=0x41 -> tx_start_o high next cycle; tx_busy_i 1 for 5 cycles then 0 -> SEND=0, TXDONE=1, tx_data_o=0x41 throughout.
REQ-036 rx_valid_i with 0x5A, then rx_valid_i with 0x33 before clearing -> RXDATA=0x33, CTRL reads 0x6.
REQ-037 CPU writes CTRL=0x2 in the same cycle as rx_valid_i -> NEW stays 1.
REQ-038 Write CTRL=0x1 while in WAIT, and write TXDATA=0xFF -> no second start, TXDATA unchanged.
REQ-039 Assert rst_i=0 during WAIT, off-edge -> tx_start_o=0 and CTRL=0 immediately; DIV=0.
REQ-040 With UART_CTRL_IRQ_EN, IE_RX=1 and rx_valid_i -> irq_o=1 one cycle after NEW sets; clearing NEW drops irq_o one cycle later.

Source files
------------

// File: rtl/uart_ctrl_regs.sv
// CPU-visible control/status registers for a UART plus a small TX start/busy sequencer.
// Optional interrupt logic and IE bits are enabled by defining UART_CTRL_IRQ_EN.
module uart_ctrl_regs #(
  parameter int DATA_W = 32,
  parameter int CHAR_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        addr_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              tx_start_o,
  output logic [CHAR_W-1:0] tx_data_o,
  input  logic              tx_busy_i,
  input  logic              rx_valid_i,
  input  logic [CHAR_W-1:0] rx_data_i,
  output logic [DIV_W-1:0]  div_o,
  output logic              irq_o,
  output logic [1:0]        tx_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } tx_state_t;

  tx_state_t         state;
  logic              send;
  logic              rx_new;
  logic              ovr;
  logic              txdone;
  logic [2:0]        ie;
  logic              tx_start;
  logic              irq;
  logic [CHAR_W-1:0] txdata;
  logic [CHAR_W-1:0] rxdata;
  logic [DIV_W-1:0]  div;

  logic wr_ctrl;
  logic wr_tx;
  logic wr_div;
  logic unused_wdata;

  assign wr_ctrl      = wr_i && (addr_i == 2'd0);
  assign wr_tx        = wr_i && (addr_i == 2'd1);
  assign wr_div       = wr_i && (addr_i == 2'd3);
  assign unused_wdata = ^wdata_i;

  // Handshake: tx_start_o stays high in START until the transmitter answers
  // with tx_busy_i=1; the transfer is complete when tx_busy_i falls in WAIT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      send     <= 1'b0;
      txdone   <= 1'b0;
      tx_start <= 1'b0;
    end else begin
      if (wr_ctrl && wdata_i[3]) txdone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_ctrl && wdata_i[0]) begin
            send     <= 1'b1;
            tx_start <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (tx_busy_i) begin
            tx_start <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!tx_busy_i) begin
            send   <= 1'b0;
            txdone <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: begin
          send     <= 1'b0;
          tx_start <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Hardware sets of NEW/OVR take priority over a same-cycle CPU clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_new <= 1'b0;
      ovr    <= 1'b0;
      txdata <= '0;
      rxdata <= '0;
      div    <= '0;
    end else begin
      if (wr_tx && !send) txdata <= wdata_i[CHAR_W-1:0];
      if (wr_div) div <= wdata_i[DIV_W-1:0];
      if (rx_valid_i) begin
        rxdata <= rx_data_i;
        rx_new <= 1'b1;
      end else if (wr_ctrl && wdata_i[1]) begin
        rx_new <= 1'b0;
      end
      if (rx_valid_i && rx_new) ovr <= 1'b1;
      else if (wr_ctrl && wdata_i[2]) ovr <= 1'b0;
    end
  end

`ifdef UART_CTRL_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ie  <= 3'b000;
      irq <= 1'b0;
    end else begin
      if (wr_ctrl) ie <= wdata_i[6:4];
      irq <= (rx_new & ie[0]) | (txdone & ie[1]) | (ovr & ie[2]);
    end
  end
`else
  assign ie  = 3'b000;
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      2'd0:    rdata_o[6:0]        = {ie, txdone, ovr, rx_new, send};
      2'd1:    rdata_o[CHAR_W-1:0] = txdata;
      2'd2:    rdata_o[CHAR_W-1:0] = rxdata;
      default: rdata_o[DIV_W-1:0]  = div;
    endcase
  end

  assign tx_start_o = tx_start;
  assign tx_data_o  = txdata;
  assign div_o      = div;
  assign irq_o      = irq;
  assign tx_state_o = state;

endmodule

// File: tb/tb_uart_ctrl_regs.sv
// Directed + randomized bench for uart_ctrl_regs with a flag/queue reference model.
// Interrupt checks follow UART_CTRL_IRQ_EN when it is defined for the build.
module tb_uart_ctrl_regs;
  localparam int DATA_W = 32;
  localparam int CHAR_W = 8;
  localparam int DIV_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        addr_i;
  logic              wr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              tx_start_o;
  logic [CHAR_W-1:0] tx_data_o;
  logic              tx_busy_i;
  logic              rx_valid_i;
  logic [CHAR_W-1:0] rx_data_i;
  logic [DIV_W-1:0]  div_o;
  logic              irq_o;
  logic [1:0]        tx_state_o;

  uart_ctrl_regs #(.DATA_W(DATA_W), .CHAR_W(CHAR_W), .DIV_W(DIV_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wr_i(wr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_busy_i(tx_busy_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .div_o(div_o), .irq_o(irq_o), .tx_state_o(tx_state_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: unread received characters are kept in exp_q.
  logic [CHAR_W-1:0] exp_q[$];
  logic              m_send, m_txdone, m_ovr;
  logic [2:0]        m_ie;
  logic [CHAR_W-1:0] m_txdata, m_rxdata;
  logic [DIV_W-1:0]  m_div;

  function automatic logic [31:0] m_ctrl();
    return {25'd0, m_ie, m_txdone, m_ovr, (exp_q.size() > 0), m_send};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_send = 0; m_txdone = 0; m_ovr = 0; m_ie = 0;
    m_txdata = 0; m_rxdata = 0; m_div = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr_i = a;
    #1;
    check(tag, rdata_o, exp);
  endtask

  // One clock of bus/rx activity, then the model applies the same cycle.
  task automatic bus_cycle(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input logic rv, input logic [CHAR_W-1:0] rd);
    logic pending;
    wr_i = w; addr_i = a; wdata_i = d; rx_valid_i = rv; rx_data_i = rd;
    @(posedge clk_i);
    #1;
    wr_i = 0; rx_valid_i = 0;
    pending = (exp_q.size() > 0);
    if (w && a == 2'd1 && !m_send) m_txdata = d[CHAR_W-1:0];
    if (w && a == 2'd3) m_div = d[DIV_W-1:0];
    if (w && a == 2'd0) begin
      if (d[1]) exp_q.delete();
      if (d[2]) m_ovr = 0;
      if (d[3]) m_txdone = 0;
`ifdef UART_CTRL_IRQ_EN
      m_ie = d[6:4];
`endif
      if (d[0]) m_send = 1;
    end
    if (rv) begin
      if (pending) m_ovr = 1;
      exp_q.push_back(rd);
      m_rxdata = rd;
    end
  endtask

  task automatic idle();
    bus_cycle(0, addr_i, 0, 0, 0);
  endtask

  task automatic tx_run(input logic [CHAR_W-1:0] ch, input int lag, input int busy_len);
    bus_cycle(1, 1, {24'd0, ch}, 0, 0);
    bus_cycle(1, 0, 32'h1, 0, 0);
    check("tx_start_rise", tx_start_o, 1);
    for (int i = 0; i < lag; i++) begin
      idle();
      check("tx_start_hold", tx_start_o, 1);
    end
    tx_busy_i = 1;
    idle();
    check("tx_start_drop", tx_start_o, 0);
    for (int i = 1; i < busy_len; i++) begin
      idle();
      check("tx_data_stable", tx_data_o, ch);
    end
    read_check("tx_send_busy", 0, m_ctrl());
    tx_busy_i = 0;
    idle();
    m_send = 0; m_txdone = 1;
    read_check("tx_done_ctrl", 0, m_ctrl());
    check("tx_start_idle", tx_start_o, 0);
    bus_cycle(1, 0, 32'h8, 0, 0);
  endtask

  initial begin
    int op;
    logic [31:0] rnd;
    rst_i = 0; addr_i = 0; wr_i = 0; wdata_i = 0;
    tx_busy_i = 0; rx_valid_i = 0; rx_data_i = 0;
    model_reset();

    // reset state
    #12;
    check("rst_tx_start", tx_start_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_div_o", div_o, 0);
    read_check("rst_ctrl", 0, 0);
    read_check("rst_txdata", 1, 0);
    read_check("rst_rxdata", 2, 0);
    read_check("rst_div", 3, 0);
    @(negedge clk_i);
    rst_i = 1;
    @(posedge clk_i);
    #1;
    read_check("post_rst_idle", 0, m_ctrl());

    // directed transmit with ignored writes during WAIT
    bus_cycle(1, 1, 32'h41, 0, 0);
    bus_cycle(1, 0, 32'h1, 0, 0);
    check("d_tx_start", tx_start_o, 1);
    check("d_tx_data", tx_data_o, 8'h41);
    read_check("d_ctrl_send", 0, 32'h1);
    tx_busy_i = 1;
    idle();
    check("d_start_drop", tx_start_o, 0);
    bus_cycle(1, 0, 32'h1, 0, 0);
    bus_cycle(1, 1, 32'hFF, 0, 0);
    check("d_no_restart", tx_start_o, 0);
    read_check("d_txdata_kept", 1, 32'h41);
    idle();
    idle();
    check("d_tx_data_hold", tx_data_o, 8'h41);
    tx_busy_i = 0;
    idle();
    m_send = 0; m_txdone = 1;
    read_check("d_txdone", 0, 32'h8);
    check("d_tx_start_low", tx_start_o, 0);
    idle();
    check("d_no_second_start", tx_start_o, 0);
    bus_cycle(1, 0, 32'h8, 0, 0);
    read_check("d_txdone_clr", 0, m_ctrl());

    // receive overrun
    bus_cycle(0, 0, 0, 1, 8'h5A);
    bus_cycle(0, 0, 0, 1, 8'h33);
    read_check("rx_overwrite", 2, 32'h33);
    read_check("rx_ovr_ctrl", 0, 32'h6);
    bus_cycle(1, 0, 32'h6, 0, 0);
    read_check("rx_clear", 0, m_ctrl());

    // set wins over same-cycle clear
    bus_cycle(0, 0, 0, 1, 8'h01);
    bus_cycle(1, 0, 32'h2, 1, 8'h02);
    read_check("set_wins_ctrl", 0, m_ctrl());
    check("set_wins_new", rdata_o[1], 1);
    bus_cycle(1, 0, 32'h6, 0, 0);

    // randomized transmits
    for (int k = 0; k < 3; k++)
      tx_run(CHAR_W'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(1, 6));

    // randomized register traffic
    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 4);
      rnd = $urandom;
      case (op)
        0: bus_cycle(0, 0, 0, 1, rnd[7:0]);
        1: bus_cycle(1, 0, {28'd0, rnd[3:1], 1'b0}, rnd[8], rnd[23:16]);
        2: bus_cycle(1, 3, rnd, 0, 0);
        3: bus_cycle(1, 2, rnd, 0, 0);
        default: bus_cycle(1, 1, rnd, 0, 0);
      endcase
      read_check("rnd_ctrl", 0, m_ctrl());
      read_check("rnd_rxdata", 2, {24'd0, m_rxdata});
      read_check("rnd_txdata", 1, {24'd0, m_txdata});
      read_check("rnd_div", 3, {16'd0, m_div});
      check("rnd_div_o", div_o, m_div);
    end
    bus_cycle(1, 0, 32'h6, 0, 0);

    // interrupt behaviour
`ifdef UART_CTRL_IRQ_EN
    bus_cycle(1, 0, 32'h10, 0, 0);
    read_check("irq_ie_rb", 0, m_ctrl());
    bus_cycle(0, 0, 0, 1, 8'h11);
    check("irq_lag", irq_o, 0);
    idle();
    check("irq_high", irq_o, 1);
    bus_cycle(1, 0, 32'h12, 0, 0);
    check("irq_hold", irq_o, 1);
    idle();
    check("irq_drop", irq_o, 0);
`else
    bus_cycle(1, 0, 32'h70, 0, 0);
    read_check("ie_ignored", 0, m_ctrl());
    bus_cycle(0, 0, 0, 1, 8'h11);
    idle();
    check("irq_tied", irq_o, 0);
    bus_cycle(1, 0, 32'h2, 0, 0);
`endif

    // asynchronous reset during WAIT
    bus_cycle(1, 3, 32'h1234, 0, 0);
    bus_cycle(1, 1, 32'h77, 0, 0);
    bus_cycle(1, 0, 32'h1, 0, 0);
    tx_busy_i = 1;
    idle();
    idle();
    addr_i = 0;
    #3;
    rst_i = 0;
    model_reset();
    #1;
    check("arst_tx_start", tx_start_o, 0);
    check("arst_ctrl", rdata_o, 0);
    check("arst_div_o", div_o, 0);
    check("arst_irq", irq_o, 0);
    #2;
    tx_busy_i = 0;
    rst_i = 1;
    idle();
    idle();
    idle();
    read_check("arst_no_txdone", 0, m_ctrl());
    read_check("arst_div", 3, 0);
    check("arst_start_low", tx_start_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
